// File: rtl/sha256_block_core_if.sv
// Block-in / digest-out bundle of the SHA-256 compression core.
// master = padder/consumer side, slave = the core.
interface sha256_block_core_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         digest_valid;
  logic [255:0] digest;
  logic         busy;

  modport master (output blk_valid, blk_data, blk_first,
                  input  blk_ready, digest_valid, digest, busy);
  modport slave  (input  blk_valid, blk_data, blk_first,
                  output blk_ready, digest_valid, digest, busy);
endinterface

// File: rtl/sha256_block_core.sv
// Sequential SHA-256 compression: UNROLL rounds per clock, chained H0..H7,
// 16-word sliding message-schedule window.
module sha256_block_core #(
  parameter int UNROLL   = 1,
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  sha256_block_core_if.slave bus
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_block_core: UNROLL must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;
  typedef logic [7:0][31:0]  vars_t;   // [7]=a/H0 ... [0]=h/H7
  typedef logic [15:0][31:0] wwin_t;   // [0] = W[t]

  localparam vars_t IHV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // kw = K[t] + W[t], pre-summed by the caller
  function automatic vars_t sha_round(input vars_t v, input logic [31:0] kw);
    logic [31:0] t1, t2;
    t1 = v[0] + (rotr(v[3], 6) ^ rotr(v[3], 11) ^ rotr(v[3], 25))
       + ((v[3] & v[2]) ^ (~v[3] & v[1])) + kw;
    t2 = (rotr(v[7], 2) ^ rotr(v[7], 13) ^ rotr(v[7], 22))
       + ((v[7] & v[6]) ^ (v[7] & v[5]) ^ (v[6] & v[5]));
    return {t1 + t2, v[7], v[6], v[5], v[4] + t1, v[3], v[2], v[1]};
  endfunction

  // Word 16 positions ahead of the head, i.e. W[t+16]
  function automatic logic [31:0] sched(input wwin_t w);
    return (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
         + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  t_q, t_d;
  wwin_t       w_q, w_d, w_rnd;
  vars_t       v_q, v_d, v_rnd;
  vars_t       h_q, h_d;
  vars_t       dig_q, dig_d;
  logic        dv_q, dv_d;

  always_comb begin
    w_rnd = w_q;
    v_rnd = v_q;
    for (int i = 0; i < UNROLL; i++) begin
      v_rnd = sha_round(v_rnd, K[t_q[5:0] + 6'(i)] + w_rnd[0]);
      w_rnd = {sched(w_rnd), w_rnd[15:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    v_d     = v_q;
    h_d     = h_q;
    dig_d   = dig_q;
    dv_d    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.blk_valid) begin
        for (int i = 0; i < 16; i++) w_d[i] = bus.blk_data[32*(15-i) +: 32];
        v_d     = bus.blk_first ? IHV : h_q;
        h_d     = v_d;
        t_d     = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        w_d = w_rnd;
        v_d = v_rnd;
        t_d = t_q + 7'(UNROLL);
        if (t_d == 7'd64) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        dig_d   = h_d;
        dv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      w_q     <= '0;
      v_q     <= '0;
      h_q     <= IHV;
      dig_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_q     <= w_d;
      v_q     <= v_d;
      h_q     <= h_d;
      dig_q   <= dig_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.blk_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.digest_valid = dv_q;
  assign bus.digest       = (OUT_HOLD || dv_q) ? dig_q : '0;
endmodule

// File: tb/tb_sha256_block_core.sv
// Bench for sha256_block_core: four instances (UNROLL 1/2/4/8, the UNROLL=2 one
// with OUT_HOLD=0) checked against known digests and an array-based SHA-256 model.
module tb_sha256_block_core;
  localparam logic [255:0] IHV   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMP = {32'h80000000, 480'h0};
  localparam logic [511:0] B_T1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_T2  = {480'h0, 32'h000001c0};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int           d;
    logic [511:0] data;
    logic         first;
    logic [255:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  int            cyc = 0;
  logic [3:0]    vld, fst, rdy, dv, bsy;
  logic [511:0]  dat [4];
  logic [3:0][255:0] dg;
  int            pulses [4];
  int            exp_pulses [4];
  logic [255:0]  model_h [4];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_block_core_if bus ();
    assign bus.blk_valid = vld[g];
    assign bus.blk_data  = dat[g];
    assign bus.blk_first = fst[g];
    assign rdy[g] = bus.blk_ready;
    assign dv[g]  = bus.digest_valid;
    assign bsy[g] = bus.busy;
    assign dg[g]  = bus.digest;
    sha256_block_core #(.UNROLL(1 << g), .OUT_HOLD(g != 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  initial for (int i = 0; i < 4; i++) pulses[i] = 0;
  always @(negedge clk) for (int i = 0; i < 4; i++) if (dv[i]) pulses[i] <= pulses[i] + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] x [8];
    logic [31:0] t1, t2;
    logic [255:0] out;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) begin hv[i] = hin[255-32*i -: 32]; x[i] = hv[i]; end
    for (int t = 0; t < 64; t++) begin
      t1 = x[7] + (rr(x[4], 6) ^ rr(x[4], 11) ^ rr(x[4], 25))
         + ((x[4] & x[5]) ^ (~x[4] & x[6])) + KT[t] + w[t];
      t2 = (rr(x[0], 2) ^ rr(x[0], 13) ^ rr(x[0], 22))
         + ((x[0] & x[1]) ^ (x[0] & x[2]) ^ (x[1] & x[2]));
      for (int i = 7; i > 0; i--) x[i] = x[i-1];
      x[4] = x[4] + t1;
      x[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) out[255-32*i -: 32] = hv[i] + x[i];
    return out;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [511:0] data, input logic first, output int xc);
    int n;
    @(negedge clk);
    vld[d] = 1'b1; dat[d] = data; fst[d] = first;
    n = 0;
    while (!rdy[d] && n < 300) begin @(negedge clk); n++; end
    if (!rdy[d]) chk_int("send_ready_timeout", 0, 1);
    @(posedge clk); #1;
    xc = cyc;
    vld[d] = 1'b0; dat[d] = rand512(); fst[d] = 1'($urandom);
    exp_pulses[d]++;
  endtask

  task automatic wait_dv(input int d, output int pc, output logic [255:0] got);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dv[d] && n < 300);
    if (!dv[d]) chk_int("digest_valid_timeout", 0, 1);
    pc = cyc;
    got = dg[d];
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk_int({tag, "_dv"}, int'(dv[d]), 0);
      chk_int({tag, "_ready"}, int'(rdy[d]), 1);
      chk_int({tag, "_busy"}, int'(bsy[d]), 0);
      chk({tag, "_digest"}, dg[d], '0);
    end
  endtask

  // valid held high: block 2 must be taken in the first IDLE cycle after block 1
  task automatic two_block(input int d);
    int x1, x2, p1, p2, n, lat;
    logic [255:0] g1, g2;
    lat = 64 / (1 << d);
    @(negedge clk);
    vld[d] = 1'b1; dat[d] = B_T1; fst[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    x1 = cyc;
    dat[d] = B_T2; fst[d] = 1'b0;
    wait_dv(d, p1, g1);
    chk("two_block_mid", g1, ref_compress(IHV, B_T1));
    chk_int("two_block_lat1", p1 - x1, lat + 1);
    @(posedge clk); #1;
    x2 = cyc;
    vld[d] = 1'b0;
    chk_int("two_block_taken", int'(bsy[d]), 1);
    wait_dv(d, p2, g2);
    chk("two_block_digest", g2, D_TWO);
    chk_int("two_block_xfer_gap", x2 - x1, lat + 2);
    chk_int("two_block_pulse_gap", p2 - p1, lat + 2);
    exp_pulses[d] += 2;
    model_h[d] = D_TWO;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [6];
    int xc, pc, d, lat;
    logic [511:0] blk;
    logic first;
    logic [255:0] got, exp;

    rst = 1'b0;
    vld = '0; fst = '0;
    for (int i = 0; i < 4; i++) begin dat[i] = '0; exp_pulses[i] = 0; model_h[i] = IHV; end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    tbl[0] = '{d: 0, data: B_ABC, first: 1'b1, exp: D_ABC};
    tbl[1] = '{d: 0, data: B_ABC, first: 1'b1, exp: D_ABC};
    tbl[2] = '{d: 1, data: B_EMP, first: 1'b1, exp: D_EMP};
    tbl[3] = '{d: 2, data: B_EMP, first: 1'b0, exp: D_EMP};
    tbl[4] = '{d: 3, data: B_EMP, first: 1'b1, exp: D_EMP};
    tbl[5] = '{d: 0, data: B_EMP, first: 1'b1, exp: D_EMP};
    for (int i = 0; i < 6; i++) begin
      d = tbl[i].d;
      send(d, tbl[i].data, tbl[i].first, xc);
      wait_dv(d, pc, got);
      chk($sformatf("vec%0d_digest", i), got, tbl[i].exp);
      chk_int($sformatf("vec%0d_latency", i), pc - xc, 64 / (1 << d) + 1);
      model_h[d] = tbl[i].exp;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("hold_out_hold1", dg[0], D_EMP);
    chk("zero_out_hold0", dg[1], '0);

    two_block(0);
    two_block(3);

    // toggling inputs while busy must neither transfer nor disturb the block
    blk = rand512();
    send(1, blk, 1'b1, xc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vld[1] = 1'($urandom); dat[1] = rand512(); fst[1] = 1'($urandom);
      #1;
      chk_int("busy_ready_low", int'(rdy[1]), 0);
      chk_int("busy_high", int'(bsy[1]), 1);
    end
    vld[1] = 1'b0;
    wait_dv(1, pc, got);
    chk("toggle_digest", got, ref_compress(IHV, blk));
    chk_int("toggle_latency", pc - xc, 33);
    @(posedge clk); #1;
    chk("toggle_zero_after", dg[1], '0);

    // reset during round ~20 aborts the block and restores IHV
    send(0, B_ABC, 1'b1, xc);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst = 1'b0;
    exp_pulses[0]--;
    for (int i = 0; i < 4; i++) model_h[i] = IHV;
    repeat (80) @(posedge clk);
    #1;
    chk_int("abort_no_pulse", pulses[0], exp_pulses[0]);
    send(0, B_ABC, 1'b0, xc);
    wait_dv(0, pc, got);
    chk("after_reset_abc", got, D_ABC);
    model_h[0] = D_ABC;

    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 3);
      blk = rand512();
      first = ($urandom_range(0, 3) == 0);
      exp = ref_compress(first ? IHV : model_h[d], blk);
      lat = 64 / (1 << d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(d, blk, first, xc);
      wait_dv(d, pc, got);
      chk($sformatf("rand%0d_u%0d_digest", i, 1 << d), got, exp);
      chk_int($sformatf("rand%0d_latency", i), pc - xc, lat + 1);
      model_h[d] = exp;
    end

    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk_int($sformatf("pulse_count_u%0d", 1 << i), pulses[i], exp_pulses[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
